// File: rtl/dac_spi_writer.sv
// SPI writer for the external current DAC: sends {CMD_WORD, i_ref} whenever the
// word differs from the last one written (or once after reset), then pulses LDAC.
module dac_spi_writer #(
  parameter int                  BUS_WIDTH   = 10,
  parameter int                  CMD_BITS    = 4,
  parameter logic [CMD_BITS-1:0] CMD_WORD    = 4'b0011,
  parameter int                  CLK_DIV     = 2,
  parameter int                  LDAC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] last_sent,
  output logic                 dac_cs_n,
  output logic                 dac_sclk,
  output logic                 dac_mosi,
  output logic                 dac_ldac_n
);

  localparam int FRAME  = CMD_BITS + BUS_WIDTH;
  localparam int BIT_W  = $clog2(FRAME + 1);
  localparam int HALF_W = $clog2(CLK_DIV + 1);
  localparam int LDAC_W = $clog2(LDAC_CYCLES + 1);

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME - 1);
  localparam logic [LDAC_W-1:0] LDAC_LAST = LDAC_W'(LDAC_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;

  state_t               state_r;
  logic [FRAME-1:0]     shreg_r;
  logic [BUS_WIDTH-1:0] data_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [HALF_W-1:0]    half_cnt_r;
  logic [LDAC_W-1:0]    ldac_cnt_r;
  logic                 sent_once_r;
  logic                 start_s;

  // A frame is needed on the first opportunity after reset or when the word moved.
  always_comb begin
    start_s = 1'b0;
    if (enable && (!sent_once_r || (i_ref != last_sent))) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Frame sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {FRAME{1'b0}};
      data_r      <= {BUS_WIDTH{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      half_cnt_r  <= {HALF_W{1'b0}};
      ldac_cnt_r  <= {LDAC_W{1'b0}};
      sent_once_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_sent   <= {BUS_WIDTH{1'b0}};
      dac_cs_n    <= 1'b1;
      dac_sclk    <= 1'b0;
      dac_mosi    <= 1'b0;
      dac_ldac_n  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_SETUP;
            shreg_r    <= {CMD_WORD, i_ref};
            data_r     <= i_ref;
            half_cnt_r <= {HALF_W{1'b0}};
            busy       <= 1'b1;
            dac_cs_n   <= 1'b0;
            dac_sclk   <= 1'b0;
            dac_mosi   <= CMD_WORD[CMD_BITS-1];
          end
        end
        ST_SETUP: begin
          if (half_cnt_r == HALF_LAST) begin
            state_r    <= ST_SHIFT;
            half_cnt_r <= {HALF_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
          end else begin
            half_cnt_r <= half_cnt_r + HALF_W'(1);
          end
        end
        ST_SHIFT: begin
          if (half_cnt_r != HALF_LAST) begin
            half_cnt_r <= half_cnt_r + HALF_W'(1);
          end else if (!dac_sclk) begin
            half_cnt_r <= {HALF_W{1'b0}};
            dac_sclk   <= 1'b1;
          end else begin
            // Falling sclk: present the next bit, or close the frame after the last.
            half_cnt_r <= {HALF_W{1'b0}};
            dac_sclk   <= 1'b0;
            if (bit_cnt_r == BIT_LAST) begin
              state_r  <= ST_HOLD;
              dac_cs_n <= 1'b1;
              dac_mosi <= 1'b0;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              shreg_r   <= {shreg_r[FRAME-2:0], 1'b0};
              dac_mosi  <= shreg_r[FRAME-2];
            end
          end
        end
        ST_HOLD: begin
          if (half_cnt_r == HALF_LAST) begin
            state_r    <= ST_LDAC;
            ldac_cnt_r <= {LDAC_W{1'b0}};
            dac_ldac_n <= 1'b0;
          end else begin
            half_cnt_r <= half_cnt_r + HALF_W'(1);
          end
        end
        ST_LDAC: begin
          if (ldac_cnt_r == LDAC_LAST) begin
            state_r     <= ST_IDLE;
            dac_ldac_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            last_sent   <= data_r;
            sent_once_r <= 1'b1;
          end else begin
            ldac_cnt_r <= ldac_cnt_r + LDAC_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          dac_cs_n   <= 1'b1;
          dac_sclk   <= 1'b0;
          dac_mosi   <= 1'b0;
          dac_ldac_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: SPI frames are decoded from the pins and matched
// against a queue of expected frame words; timing and corner cases checked alongside.
module tb_dac_spi_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] i_ref;
  logic       busy, done, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n;
  logic [9:0] last_sent;

  dac_spi_writer dut (
    .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref),
    .busy(busy), .done(done), .last_sent(last_sent),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi),
    .dac_ldac_n(dac_ldac_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_seen = 0;
  int dones_seen  = 0;
  int exp_frames  = 0;
  logic [13:0] exp_q[$];
  logic [9:0]  exp_last = 10'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [9:0] d);
    exp_q.push_back({4'b0011, d});
    exp_frames++;
  endtask

  // Counts cycles until done is seen; an expired bound is a failed comparison.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      tick();
      cyc++;
      if (done) return;
    end
    check("done_timeout", 32'(cyc), 32'(limit + 1));
  endtask

  // Pin-level SPI monitor sampling on the falling clk edge.
  int          nbits = 0, cs_low = 0, ldac_low = 0;
  logic [13:0] shift_acc = 14'h0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; cs_low = 0; ldac_low = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
    end else begin
      if (!dac_cs_n) begin
        cs_low++;
        if (dac_sclk && !prev_sclk) begin
          shift_acc = {shift_acc[12:0], dac_mosi};
          nbits++;
        end
      end
      if (dac_cs_n && !prev_cs) begin
        check("frame_bits", 32'(nbits), 32'd14);
        check("cs_low_cycles", 32'(cs_low), 32'd58);
        check("sclk_ends_low", 32'(dac_sclk), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {18'h0, shift_acc}, 32'hFFFF_FFFF);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          check("frame_word", {18'h0, shift_acc}, {18'h0, e});
          exp_last = e[9:0];
        end
        frames_seen++;
        nbits = 0; cs_low = 0;
      end
      if (!dac_ldac_n) ldac_low++;
      if (done) begin
        check("ldac_low_cycles", 32'(ldac_low), 32'd2);
        check("last_sent", {22'h0, last_sent}, {22'h0, exp_last});
        check("done_busy_excl", 32'(busy), 32'd0);
        ldac_low = 0;
        dones_seen++;
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
    end
  end

  typedef struct {
    logic       en;
    logic [9:0] data;
    logic       exp_frame;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int cyc;
    int bad;
    vecs[0] = '{1'b1, 10'h000, 1'b1};
    vecs[1] = '{1'b1, 10'h2A5, 1'b1};
    vecs[2] = '{1'b1, 10'h2A5, 1'b0};
    vecs[3] = '{1'b0, 10'h050, 1'b0};
    vecs[4] = '{1'b1, 10'h050, 1'b1};
    vecs[5] = '{1'b1, 10'h1C3, 1'b1};
    vecs[6] = '{1'b1, 10'h1C3, 1'b0};
    vecs[7] = '{1'b0, 10'h3FF, 1'b0};
    vecs[8] = '{1'b1, 10'h3FF, 1'b1};

    rst = 1'b1; enable = 1'b0; i_ref = 10'h000;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_last_sent", {22'h0, last_sent}, 32'd0);
    check("rst_cs_n", 32'(dac_cs_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd0);
    check("rst_mosi", 32'(dac_mosi), 32'd0);
    check("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      enable = vecs[i].en;
      i_ref  = vecs[i].data;
      if (vecs[i].exp_frame) begin
        push_exp(vecs[i].data);
        wait_done(150, cyc);
        check("done_latency", 32'(cyc), 32'd63);
        check("vec_last_sent", {22'h0, last_sent}, {22'h0, vecs[i].data});
      end else begin
        bad = 0;
        for (int k = 0; k < 100; k++) begin
          tick();
          if (busy || !dac_cs_n) bad++;
        end
        check("vec_no_frame", 32'(bad), 32'd0);
      end
    end

    // Settled word must not produce bus traffic.
    i_ref = 10'h2A5;
    push_exp(10'h2A5);
    wait_done(150, cyc);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (busy || !dac_cs_n || !dac_ldac_n) bad++;
    end
    check("hold_quiet", 32'(bad), 32'd0);

    // Mid-frame updates coalesce to the latest word, sent right after done.
    i_ref = 10'h100;
    push_exp(10'h100);
    repeat (5) tick();
    i_ref = 10'h101;
    repeat (10) tick();
    i_ref = 10'h3FF;
    push_exp(10'h3FF);
    wait_done(150, cyc);
    check("coalesce_first_last", {22'h0, last_sent}, 32'h100);
    tick();
    check("coalesce_next_setup", 32'(busy), 32'd1);
    wait_done(150, cyc);
    check("coalesce_latency", 32'(cyc), 32'd62);
    check("coalesce_last", {22'h0, last_sent}, 32'h3FF);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (busy) bad++;
    end
    check("coalesce_single", 32'(bad), 32'd0);

    // Reset during SHIFT bit 5 aborts without a done pulse.
    i_ref = 10'h155;
    push_exp(10'h155);
    cyc = 0;
    while (!busy && cyc < 10) begin
      tick();
      cyc++;
    end
    check("abort_started", 32'(busy), 32'd1);
    repeat (22) tick();
    rst = 1'b1;
    tick();
    check("abort_cs_n", 32'(dac_cs_n), 32'd1);
    check("abort_sclk", 32'(dac_sclk), 32'd0);
    check("abort_ldac_n", 32'(dac_ldac_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_last_sent", {22'h0, last_sent}, 32'd0);
    exp_q.delete();
    exp_frames--;
    rst = 1'b0;
    push_exp(10'h155);
    wait_done(150, cyc);
    check("resend_latency", 32'(cyc), 32'd63);
    check("resend_last", {22'h0, last_sent}, 32'h155);
    repeat (5) tick();

    check("frames_seen", 32'(frames_seen), 32'(exp_frames));
    check("dones_seen", 32'(dones_seen), 32'(exp_frames));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_spi_writer.md
Name: dac_spi_writer

Overview:
- Downstream stage of the front-end current-reference chain: consumes the final i_ref_out word and writes it to the external current DAC over a write-only SPI link, then pulses LDAC.
- Sends a frame only when the word changes, or once after reset, so the bisection loop's settled value does not cause bus traffic.
- Coalesces updates that arrive mid-frame: after the frame ends, only the latest value is sent.

Parameters:
- BUS_WIDTH, 10, width of the i_ref data word.
- CMD_BITS, 4, width of the command prefix.
- CMD_WORD, 4'b0011, command prefix ("write and update"); sent MSB first, ahead of the data.
- CLK_DIV, 2, clk cycles per dac_sclk half-period; must be >= 1.
- LDAC_CYCLES, 2, width of the dac_ldac_n low pulse in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new frames to start; a frame already in progress always completes.
- i_ref  in  BUS_WIDTH  current-reference word to write (the i_ref_out bus).
- busy  out  1  high from the first SETUP cycle through the last LDAC cycle.
- done  out  1  one-cycle pulse in the cycle after the last LDAC cycle.
- last_sent  out  BUS_WIDTH  last word fully written, updated together with done.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sclk  out  1  SPI clock, mode 0, idle low.
- dac_mosi  out  1  SPI data, MSB first.
- dac_ldac_n  out  1  DAC load strobe, active low.

Behaviour:
- Reset values: busy=0, done=0, last_sent=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1. Internal sent_once=0, state=IDLE.
- Reset asserted mid-frame aborts at the next edge; all outputs return to reset values and no done pulse is produced.
- Frame word (FRAME = CMD_BITS+BUS_WIDTH bits) = {CMD_WORD, i_ref}, captured in a shift register.
- States:
  - IDLE -> SETUP when enable && (!sent_once || i_ref != last_sent), evaluated in cycle N. The frame word is captured at the end of cycle N.
  - SETUP (CLK_DIV cycles): in cycle N+1, cs_n=0, busy=1, mosi=frame MSB, sclk=0.
  - SHIFT (2*CLK_DIV*FRAME cycles): each bit is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. The DAC samples on the rising edge. mosi changes only on the sclk falling transition, to the next bit. sclk ends low.
  - HOLD (CLK_DIV cycles): cs_n=1, sclk=0, mosi=0.
  - LDAC (LDAC_CYCLES cycles): ldac_n=0.
  - -> IDLE: done=1 for one cycle, last_sent=captured data, sent_once=1, busy=0.
- Default total busy time: 2 + 56 + 2 + 2 = 62 cycles.
- i_ref changes during busy are ignored until IDLE. The earliest new SETUP is in the cycle after the done pulse, i.e. done and busy are never high together. An intermediate value that reverts to last_sent before IDLE causes no frame.
- enable low in IDLE: stays in IDLE, no frame. Changes to enable mid-frame have no effect.
- No X on any output after reset. Bit counter width is clog2(FRAME+1); half-period counter width is clog2(CLK_DIV+1).

Test Plan:
- rst for 3 cycles, then enable=1, i_ref=10'h000 -> a frame is still sent (sent_once=0). Bits = 0011_0000000000. done occurs 63 cycles after enable rises. last_sent=0.
- i_ref=10'h2A5 after idle -> cs_n low for exactly 2+56 cycles. Bench samples 14 rising sclk edges = 0011_1010100101. ldac_n low for exactly 2 cycles after cs_n rises, then done pulse.
- i_ref held constant at 10'h2A5 for 200 cycles after its frame -> no further cs_n activity, busy stays 0.
- During a frame, i_ref steps 10'h100 -> 10'h101 -> 10'h3FF -> exactly one following frame with data 10'h3FF, starting the cycle after done. 10'h101 is never transmitted.
- enable=0 with i_ref=10'h050 != last_sent -> no frame. enable raised -> SETUP on the next cycle.
- rst pulsed during SHIFT bit 5 -> cs_n=1, sclk=0, ldac_n=1, busy=0 on the next edge, no done. last_sent=0. A new frame is sent once enable is high.
